mod16_wrap_monitor: RTL and testbench

- Downstream consumer of the free-running 4-bit mod-16 counter output.
- Detects each 15->0 wrap and counts wraps in a WRAP_W-bit accumulator.
- Raises a handshaked event each time the accumulator reaches a programmable target, which makes it a programmable divide-by-N of counter wraps.
- Optionally flags counter sequence errors.

---
 rtl/mod16_pkg.sv | 19 +
 rtl/mod16_wrap_detect.sv | 58 +++++
 rtl/mod16_wrap_monitor.sv | 140 ++++++++++++++
 tb/tb_mod16_wrap_monitor.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mod16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mod16_pkg
// Description : Shared definitions for the mod-16 counter wrap monitor:
//               counter width, terminal count and the detector state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package mod16_pkg;

   localparam int                 COUNT_W   = 4;
   localparam logic [COUNT_W-1:0] COUNT_MAX = 4'd15;

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_TRACK = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/mod16_wrap_detect.sv
`default_nettype none
// ============================================================================
// Module      : mod16_wrap_detect
// Description : Tracks the previous counter sample and flags 15->0 wraps and,
//               when MOD16_WRAP_MONITOR_ERR_CHECK_EN is defined, sequence
//               errors. The first sample after reset only seeds the history.
// Ports       : clk        rising-edge clock
//               reset_n    asynchronous active-low reset
//               count_i    current counter value
//               wrap_hit_o 15->0 transition seen this cycle (combinational)
//               seq_hit_o  illegal step seen this cycle (ERR_CHECK_EN only)
// Config      : MOD16_WRAP_MONITOR_ERR_CHECK_EN enables the sequence check
// Revision    : 1.0  initial release
// ============================================================================
module mod16_wrap_detect
   import mod16_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic [COUNT_W-1:0] count_i,
`ifdef MOD16_WRAP_MONITOR_ERR_CHECK_EN
   output logic               seq_hit_o,
`endif
   output logic               wrap_hit_o
);

   state_t             state_q, state_d;
   logic [COUNT_W-1:0] prev_q, prev_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_INIT;
         prev_q  <= '0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
      end
   end

   // INIT lasts exactly one sample: it captures history and moves on.
   always_comb begin
      state_d = ST_TRACK;
      prev_d  = count_i;
   end

   assign wrap_hit_o = (state_q == ST_TRACK) && (prev_q == COUNT_MAX) &&
                       (count_i == '0);

`ifdef MOD16_WRAP_MONITOR_ERR_CHECK_EN
   logic [COUNT_W-1:0] succ;
   assign succ = prev_q + COUNT_W'(1);
   // A jump to 0 is a counter resync, never an error.
   assign seq_hit_o = (state_q == ST_TRACK) && (count_i != succ) &&
                      (count_i != '0);
`endif

endmodule
`default_nettype wire

// File: rtl/mod16_wrap_monitor.sv
`default_nettype none
// ============================================================================
// Module      : mod16_wrap_monitor
// Description : Counts wraps of a free-running mod-16 counter and raises a
//               valid/ready event each time the wrap count reaches target,
//               acting as a programmable divide-by-N of counter wraps.
// Ports       : clk, reset_n      clock, asynchronous active-low reset
//               count_in          counter value sampled every clk
//               clear             synchronous clear of count, event, flags
//               target            match value (0 disables matching)
//               wrap_cnt          accumulator value
//               wrap_pulse        one-cycle pulse per wrap
//               evt_valid/ready   event handshake, evt_wraps payload
//               evt_overrun       sticky: match lost, event slot full
//               seq_err           sticky sequence error (0 unless enabled)
// Config      : MOD16_WRAP_MONITOR_ERR_CHECK_EN enables seq_err
// Revision    : 1.0  initial release
// ============================================================================
module mod16_wrap_monitor
   import mod16_pkg::*;
#(
   parameter int WRAP_W = 8
)(
   input  logic               clk,
   input  logic               reset_n,
   input  logic [COUNT_W-1:0] count_in,
   input  logic               clear,
   input  logic [WRAP_W-1:0]  target,
   output logic [WRAP_W-1:0]  wrap_cnt,
   output logic               wrap_pulse,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic [WRAP_W-1:0]  evt_wraps,
   output logic               evt_overrun,
   output logic               seq_err
);

   logic              wrap_hit;
   logic [WRAP_W-1:0] next_cnt;
   logic              match;

   logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
   logic              wrap_pulse_q, wrap_pulse_d;
   logic              evt_valid_q, evt_valid_d;
   logic [WRAP_W-1:0] evt_wraps_q, evt_wraps_d;
   logic              evt_overrun_q, evt_overrun_d;

`ifdef MOD16_WRAP_MONITOR_ERR_CHECK_EN
   logic seq_hit;
   logic seq_err_q, seq_err_d;
`endif

   mod16_wrap_detect u_detect (
      .clk        (clk),
      .reset_n    (reset_n),
      .count_i    (count_in),
`ifdef MOD16_WRAP_MONITOR_ERR_CHECK_EN
      .seq_hit_o  (seq_hit),
`endif
      .wrap_hit_o (wrap_hit)
   );

   assign next_cnt = wrap_cnt_q + WRAP_W'(1);
   assign match    = wrap_hit && (target != '0) && (next_cnt == target);

   always_comb begin
      wrap_cnt_d    = wrap_cnt_q;
      wrap_pulse_d  = 1'b0;
      evt_valid_d   = evt_valid_q;
      evt_wraps_d   = evt_wraps_q;
      evt_overrun_d = evt_overrun_q;
`ifdef MOD16_WRAP_MONITOR_ERR_CHECK_EN
      seq_err_d     = seq_err_q;
`endif
      if (clear) begin
         // Clear wins over everything; a wrap sampled now is dropped.
         wrap_cnt_d    = '0;
         evt_valid_d   = 1'b0;
         evt_overrun_d = 1'b0;
`ifdef MOD16_WRAP_MONITOR_ERR_CHECK_EN
         seq_err_d     = 1'b0;
`endif
      end else begin
         wrap_pulse_d = wrap_hit;
         if (wrap_hit) begin
            wrap_cnt_d = match ? '0 : next_cnt;
         end
         if (evt_valid_q && evt_ready) begin
            evt_valid_d = 1'b0;
         end
         // A load may reuse the slot being drained in the same cycle.
         if (match) begin
            if (!evt_valid_q || evt_ready) begin
               evt_valid_d = 1'b1;
               evt_wraps_d = target;
            end else begin
               evt_overrun_d = 1'b1;
            end
         end
`ifdef MOD16_WRAP_MONITOR_ERR_CHECK_EN
         seq_err_d = seq_err_q | seq_hit;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wrap_cnt_q    <= '0;
         wrap_pulse_q  <= 1'b0;
         evt_valid_q   <= 1'b0;
         evt_wraps_q   <= '0;
         evt_overrun_q <= 1'b0;
`ifdef MOD16_WRAP_MONITOR_ERR_CHECK_EN
         seq_err_q     <= 1'b0;
`endif
      end else begin
         wrap_cnt_q    <= wrap_cnt_d;
         wrap_pulse_q  <= wrap_pulse_d;
         evt_valid_q   <= evt_valid_d;
         evt_wraps_q   <= evt_wraps_d;
         evt_overrun_q <= evt_overrun_d;
`ifdef MOD16_WRAP_MONITOR_ERR_CHECK_EN
         seq_err_q     <= seq_err_d;
`endif
      end
   end

   assign wrap_cnt    = wrap_cnt_q;
   assign wrap_pulse  = wrap_pulse_q;
   assign evt_valid   = evt_valid_q;
   assign evt_wraps   = evt_wraps_q;
   assign evt_overrun = evt_overrun_q;
`ifdef MOD16_WRAP_MONITOR_ERR_CHECK_EN
   assign seq_err     = seq_err_q;
`else
   assign seq_err     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mod16_wrap_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod16_wrap_monitor
// Description : Directed self-checking bench for mod16_wrap_monitor.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mod16_wrap_monitor;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] count_in = 4'd0;
   logic       clear = 1'b0;
   logic [7:0] target = 8'd0;
   logic [7:0] wrap_cnt;
   logic       wrap_pulse;
   logic       evt_valid;
   logic       evt_ready = 1'b0;
   logic [7:0] evt_wraps;
   logic       evt_overrun;
   logic       seq_err;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef MOD16_WRAP_MONITOR_ERR_CHECK_EN
   localparam logic EXP_SEQ = 1'b1;
`else
   localparam logic EXP_SEQ = 1'b0;
`endif

   mod16_wrap_monitor #(.WRAP_W(8)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .count_in    (count_in),
      .clear       (clear),
      .target      (target),
      .wrap_cnt    (wrap_cnt),
      .wrap_pulse  (wrap_pulse),
      .evt_valid   (evt_valid),
      .evt_ready   (evt_ready),
      .evt_wraps   (evt_wraps),
      .evt_overrun (evt_overrun),
      .seq_err     (seq_err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one counter value, let one edge sample it, settle past the edge.
   task automatic step(input logic [3:0] v);
      @(negedge clk);
      count_in = v;
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int lo, input int hi);
      for (int v = lo; v <= hi; v++) step(4'(v));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset state
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_cnt", wrap_cnt, 0);
      check_val("rst_pulse", wrap_pulse, 0);
      check_val("rst_valid", evt_valid, 0);
      check_val("rst_wraps", evt_wraps, 0);
      check_val("rst_ovr", evt_overrun, 0);
      check_val("rst_seq", seq_err, 0);
      @(negedge clk);
      reset_n = 1'b1;
      target  = 8'd3;

      // ---- target=3: three wraps to an event
      step(4'd0);
      check_val("init_pulse", wrap_pulse, 0);
      steps(1, 15); step(4'd0);
      check_val("w1_pulse", wrap_pulse, 1);
      check_val("w1_cnt", wrap_cnt, 1);
      step(4'd1);
      check_val("w1_pulse_end", wrap_pulse, 0);
      steps(2, 15); step(4'd0);
      check_val("w2_cnt", wrap_cnt, 2);
      check_val("w2_valid", evt_valid, 0);
      steps(1, 15); step(4'd0);
      check_val("w3_cnt", wrap_cnt, 0);
      check_val("w3_valid", evt_valid, 1);
      check_val("w3_wraps", evt_wraps, 3);
      evt_ready = 1'b1;
      step(4'd1);
      evt_ready = 1'b0;
      check_val("xfer1_valid", evt_valid, 0);

      // ---- target=2, consumer stalled over four wraps
      target = 8'd2;
      steps(2, 15); step(4'd0);
      check_val("t2_w1_cnt", wrap_cnt, 1);
      steps(1, 15); step(4'd0);
      check_val("t2_w2_valid", evt_valid, 1);
      check_val("t2_w2_wraps", evt_wraps, 2);
      check_val("t2_w2_ovr", evt_overrun, 0);
      steps(1, 15); step(4'd0);
      steps(1, 15); step(4'd0);
      check_val("t2_w4_ovr", evt_overrun, 1);
      check_val("t2_w4_valid", evt_valid, 1);
      check_val("t2_w4_wraps", evt_wraps, 2);
      check_val("t2_w4_cnt", wrap_cnt, 0);
      evt_ready = 1'b1;
      step(4'd1);
      evt_ready = 1'b0;
      check_val("t2_xfer_valid", evt_valid, 0);
      check_val("t2_ovr_sticky", evt_overrun, 1);

      // ---- clear, then target=1 with transfer coinciding with a new load
      clear = 1'b1;
      step(4'd2);
      clear = 1'b0;
      check_val("clr_ovr", evt_overrun, 0);
      target = 8'd1;
      steps(3, 15); step(4'd0);
      check_val("t1_valid", evt_valid, 1);
      check_val("t1_wraps", evt_wraps, 1);
      steps(1, 15);
      check_val("t1_hold_valid", evt_valid, 1);
      evt_ready = 1'b1;
      step(4'd0);
      check_val("b2b_valid", evt_valid, 1);
      check_val("b2b_ovr", evt_overrun, 0);
      check_val("b2b_wraps", evt_wraps, 1);
      step(4'd1);
      evt_ready = 1'b0;
      check_val("b2b_drain", evt_valid, 0);

      // ---- counter resync (jump to 0 from 6) and illegal step 5->7
      target = 8'd0;
      steps(2, 15); step(4'd0);
      check_val("rs_cnt_pre", wrap_cnt, 1);
      steps(1, 6); step(4'd0);
      check_val("rs_pulse0", wrap_pulse, 0);
      step(4'd1);
      check_val("rs_pulse1", wrap_pulse, 0);
      check_val("rs_cnt", wrap_cnt, 1);
      check_val("rs_seq", seq_err, 0);
      steps(2, 5); step(4'd7);
      check_val("seq_jump", seq_err, EXP_SEQ);

      // ---- clear on the cycle a wrap is sampled
      steps(8, 15); step(4'd0);
      check_val("cw_cnt_pre", wrap_cnt, 2);
      steps(1, 15);
      clear = 1'b1;
      step(4'd0);
      clear = 1'b0;
      check_val("cw_cnt", wrap_cnt, 0);
      check_val("cw_pulse", wrap_pulse, 0);
      check_val("cw_valid", evt_valid, 0);
      check_val("cw_seq", seq_err, 0);
      step(4'd1);
      check_val("cw_pulse_late", wrap_pulse, 0);

      // ---- asynchronous reset with an event pending
      target = 8'd1;
      steps(2, 15); step(4'd0);
      check_val("ar_valid_pre", evt_valid, 1);
      target = 8'd0;
      steps(1, 15); step(4'd0);
      check_val("ar_cnt_pre", wrap_cnt, 1);
      steps(1, 15);
      #2;
      reset_n = 1'b0;
      #1;
      check_val("ar_cnt", wrap_cnt, 0);
      check_val("ar_valid", evt_valid, 0);
      check_val("ar_wraps", evt_wraps, 0);
      check_val("ar_pulse", wrap_pulse, 0);
      @(negedge clk);
      reset_n = 1'b1;
      count_in = 4'd0;
      @(posedge clk);
      #1;
      check_val("ar_first_pulse", wrap_pulse, 0);
      check_val("ar_first_cnt", wrap_cnt, 0);
      steps(1, 15); step(4'd0);
      check_val("ar_track_pulse", wrap_pulse, 1);
      check_val("ar_track_cnt", wrap_cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
